// File: rtl/avr_uart_tx_gated.sv
// 8N1 UART transmitter toward the AVR. Bytes are queued in a small FIFO and sent
// LSB first. Nothing is sent while the cclk detector reports the AVR as not ready,
// and each new frame waits for the AVR's tx_block line to be released.
module avr_uart_tx_gated #(
    parameter int unsigned CLK_RATE    = 50_000_000,
    parameter int unsigned BAUD        = 500_000,
    parameter int unsigned CLK_PER_BIT = CLK_RATE / BAUD,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         avr_ready,
    input  logic                         tx_block,
    input  logic [7:0]                   in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         tx,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned TMR_W = $clog2(CLK_PER_BIT);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(CLK_PER_BIT - 1);
    localparam logic [PTR_W:0] COUNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    // tx_block synchroniser; resets to "blocked" so nothing leaves before it settles.
    logic blk_meta;
    logic blk_s;

    // FIFO storage and bookkeeping; the count carries one extra bit so full != empty.
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count_q;
    logic             push;
    logic             pop;

    // Frame engine.
    state_e           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;

    assign in_ready   = avr_ready & (count_q != COUNT_FULL);
    assign push       = in_valid & in_ready;
    assign fifo_count = count_q;
    assign busy       = (state_q != StIdle) | (count_q != '0);

    // Two-flop synchroniser for the asynchronous AVR busy line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_meta <= 1'b1;
            blk_s    <= 1'b1;
        end else begin
            blk_meta <= tx_block;
            blk_s    <= blk_meta;
        end
    end

    // FIFO data array; contents need no reset since the count qualifies every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and count; losing avr_ready flushes everything queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (!avr_ready) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Frame engine state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            tmr_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Frame engine next state, FIFO pop and line level.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        tx      = 1'b1;

        unique case (state_q)
            StIdle: begin
                tx = 1'b1;
                // tx_block is only honoured here, so a frame in flight always completes.
                if (avr_ready && !blk_s && (count_q != '0)) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
                    tmr_d   = TMR_LOAD;
                    bit_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                tx = 1'b0;
                if (tmr_q == '0) begin
                    tmr_d   = TMR_LOAD;
                    state_d = StData;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            StData: begin
                tx = shift_q[0];
                if (tmr_q == '0) begin
                    tmr_d   = TMR_LOAD;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            StStop: begin
                tx = 1'b1;
                if (tmr_q == '0) begin
                    state_d = StIdle;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // AVR not configured: abort any partial frame.
        if (!avr_ready) begin
            state_d = StIdle;
            pop     = 1'b0;
        end
    end

endmodule
